adc_capture: RTL and testbench

- Parametrised successor to the fixed 8-bit ADC clock/data hookup between the Digital and adc instances in core.
- Generates a programmable ADC conversion clock and samples adc_data once per conversion.
- Optionally averages 2^N samples, then buffers results in a FIFO with a valid/ready output port toward the digital subsystem.
- Reports sample loss through a sticky overflow flag.

---
 rtl/adc_capture_pkg.sv | 21 ++
 rtl/adc_capture_sync_fifo.sv | 52 +++++
 rtl/adc_capture.sv | 129 ++++++++++++
 tb/tb_adc_capture.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and width helpers for the ADC capture path.
package adc_capture_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Accumulator is wide enough to sum 2^dec_max_log2 full-scale samples.
  function automatic int acc_width(input int data_w, input int dec_max_log2);
    return data_w + dec_max_log2;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int FIFO_DEPTH_DEF = 8;
  localparam int CNT_W          = cnt_width(FIFO_DEPTH_DEF);

endpackage

// File: rtl/adc_capture_sync_fifo.sv
// Synchronous FIFO; a push while full is taken only if a pop frees a slot in the same cycle.
module sync_fifo
  import adc_capture_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            push_data_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            head_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [cnt_width(DEPTH)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_q == (PW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);
  assign count_o   = count_q;
  // Empty FIFO presents zero so the head reads clean after reset.
  assign head_o    = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(push_ok_s) - (PW+1)'(pop_ok_s);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_s) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/adc_capture.sv
// ADC conversion clock generator, sample averager and buffered output port.
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DIV_W        = 8,
  parameter int DEC_MAX_LOG2 = 7,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [DIV_W-1:0]                 clk_div,
  input  logic [2:0]                       dec_log2,
  output logic                             adc_clock,
  input  logic [DATA_W-1:0]                adc_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W-1:0]                out_data,
  output logic [cnt_width(FIFO_DEPTH)-1:0] fifo_count,
  output logic                             overflow,
  input  logic                             clear_overflow
);

  localparam int ACC_W = acc_width(DATA_W, DEC_MAX_LOG2);
  localparam int SC_W  = (DEC_MAX_LOG2 > 0) ? DEC_MAX_LOG2 : 1;

  state_e            state_q;
  logic [DIV_W-1:0]  cfg_div_q;
  logic [2:0]        cfg_dec_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic              adc_clk_q;
  logic [ACC_W-1:0]  acc_q;
  logic [SC_W-1:0]   scnt_q;
  logic              overflow_q;

  logic              div_wrap_s;
  logic              samp_s;
  logic              push_s;
  logic [SC_W-1:0]   scnt_last_s;
  logic [ACC_W-1:0]  sum_s;
  logic [DATA_W-1:0] avg_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              drop_s;

  // Sampling happens on the edge that raises adc_clock; a falling enable suppresses it.
  assign div_wrap_s  = (div_cnt_q == cfg_div_q);
  assign samp_s      = (state_q == RUN) && enable && div_wrap_s && !adc_clk_q;
  assign scnt_last_s = SC_W'((32'd1 << cfg_dec_q) - 32'd1);
  assign push_s      = samp_s && (scnt_q == scnt_last_s);
  assign sum_s       = acc_q + ACC_W'(adc_data);
  assign avg_s       = DATA_W'(sum_s >> cfg_dec_q);
  assign out_valid   = !fifo_empty_s;
  assign drop_s      = push_s && fifo_full_s && !(out_valid && out_ready);

  // Run/idle control, conversion clock divider and decimating accumulator.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cfg_div_q <= '0;
      cfg_dec_q <= '0;
      div_cnt_q <= '0;
      adc_clk_q <= 1'b0;
      acc_q     <= '0;
      scnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q   <= RUN;
            cfg_div_q <= clk_div;
            cfg_dec_q <= (32'(dec_log2) > DEC_MAX_LOG2) ? 3'(DEC_MAX_LOG2) : dec_log2;
          end
        end
        RUN: begin
          if (!enable) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            adc_clk_q <= 1'b0;
            acc_q     <= '0;
            scnt_q    <= '0;
          end else begin
            if (div_wrap_s) begin
              div_cnt_q <= '0;
              adc_clk_q <= ~adc_clk_q;
            end else begin
              div_cnt_q <= div_cnt_q + DIV_W'(1);
            end
            if (push_s) begin
              acc_q  <= '0;
              scnt_q <= '0;
            end else if (samp_s) begin
              acc_q  <= sum_s;
              scnt_q <= scnt_q + SC_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky loss flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clock) begin
    if (reset)               overflow_q <= 1'b0;
    else if (drop_s)         overflow_q <= 1'b1;
    else if (clear_overflow) overflow_q <= 1'b0;
  end

  assign adc_clock = adc_clk_q;
  assign overflow  = overflow_q;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (push_s),
    .push_data_i (avg_s),
    .pop_i       (out_ready),
    .head_o      (out_data),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_adc_capture.sv
// Scoreboard bench for adc_capture: expected averages queued at each strobe, compared as they drain.
module tb_adc_capture;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] clk_div = 8'd0;
  logic [2:0] dec_log2 = 3'd0;
  logic       adc_clock;
  logic [7:0] adc_data = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       clear_overflow = 1'b0;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  adc_capture dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .clk_div        (clk_div),
    .dec_log2       (dec_log2),
    .adc_clock      (adc_clock),
    .adc_data       (adc_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Advance until adc_clock rises (the strobe edge); n = cycles taken.
  task automatic wait_strobe(output int n);
    logic prev;
    logic hit;
    hit = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      prev = adc_clock;
      tick();
      n++;
      if (!prev && adc_clock) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check_val("strobe_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    tick();
    check_val("drain_left", exp_q.size(), 32'd0);
    check_val("drain_count", fifo_count, 32'd0);
  endtask

  // Consumer side: each handshake pops the scoreboard.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check_val("unexpected_out", {24'd0, out_data}, 32'hFFFF_FFFF);
      else check_val("out_data", out_data, exp_q.pop_front());
    end
  end

  initial begin
    int n;
    tick();
    tick();
    reset = 1'b0;
    check_val("rst_adc_clock", adc_clock, 32'd0);
    check_val("rst_valid", out_valid, 32'd0);
    check_val("rst_data", out_data, 32'd0);
    check_val("rst_count", fifo_count, 32'd0);
    check_val("rst_ovf", overflow, 32'd0);

    // Divider: first rise 4 cycles after entry, then period 8.
    clk_div = 8'd3; dec_log2 = 3'd0; adc_data = 8'h5A; out_ready = 1'b1; enable = 1'b1;
    tick();
    wait_strobe(n);
    check_val("first_rise", n, 32'd4);
    exp_q.push_back(8'h5A);
    check_val("div_valid", out_valid, 32'd1);
    check_val("div_data", out_data, 32'h5A);
    for (int i = 0; i < 2; i++) begin
      wait_strobe(n);
      check_val("period", n, 32'd8);
      exp_q.push_back(8'h5A);
    end
    enable = 1'b0;
    tick();
    check_val("idle_adc_clock", adc_clock, 32'd0);
    drain();

    // Averaging 4 samples: 10,20,30,41 -> 25.
    clk_div = 8'd1; dec_log2 = 3'd2; adc_data = 8'd10; enable = 1'b1;
    tick();
    wait_strobe(n); check_val("avg_nopush1", out_valid, 32'd0); adc_data = 8'd20;
    wait_strobe(n); check_val("avg_nopush2", out_valid, 32'd0); adc_data = 8'd30;
    wait_strobe(n); check_val("avg_nopush3", out_valid, 32'd0); adc_data = 8'd41;
    wait_strobe(n);
    exp_q.push_back(8'd25);
    check_val("avg_valid", out_valid, 32'd1);
    check_val("avg_data", out_data, 32'd25);
    enable = 1'b0;
    drain();

    // Full FIFO: eight stored, ninth dropped.
    out_ready = 1'b0; clk_div = 8'd0; dec_log2 = 3'd0; adc_data = 8'h30; enable = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      wait_strobe(n);
      if (i < 8) exp_q.push_back(8'(8'h30 + i));
      if (i == 7) begin
        check_val("full_count", fifo_count, 32'd8);
        check_val("full_no_ovf", overflow, 32'd0);
      end
      adc_data = 8'(8'h31 + i);
    end
    check_val("drop_count", fifo_count, 32'd8);
    check_val("drop_ovf", overflow, 32'd1);
    enable = 1'b0;
    tick();
    drain();

    // Full with concurrent pop on the push cycle.
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check_val("ovf_cleared", overflow, 32'd0);
    out_ready = 1'b0; clk_div = 8'd1; adc_data = 8'h60; enable = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      wait_strobe(n);
      exp_q.push_back(8'(8'h60 + i));
      adc_data = 8'(8'h61 + i);
    end
    tick(); tick(); tick();
    out_ready = 1'b1;
    wait_strobe(n);
    out_ready = 1'b0;
    exp_q.push_back(8'h68);
    check_val("cpop_strobe", n, 32'd1);
    check_val("cpop_count", fifo_count, 32'd8);
    check_val("cpop_ovf", overflow, 32'd0);
    enable = 1'b0;
    drain();

    // Mid-average disable discards the partial sum.
    out_ready = 1'b1; clk_div = 8'd1; dec_log2 = 3'd3; adc_data = 8'd7; enable = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) wait_strobe(n);
    enable = 1'b0;
    tick();
    check_val("dis_adc_clock", adc_clock, 32'd0);
    check_val("dis_no_push", out_valid, 32'd0);
    dec_log2 = 3'd1; adc_data = 8'd100; enable = 1'b1;
    tick();
    wait_strobe(n); check_val("re_nopush", out_valid, 32'd0); adc_data = 8'd51;
    wait_strobe(n);
    exp_q.push_back(8'd75);
    check_val("re_valid", out_valid, 32'd1);
    check_val("re_data", out_data, 32'd75);
    enable = 1'b0;
    drain();

    // Clear coinciding with a drop, then reset mid-run.
    out_ready = 1'b0; clk_div = 8'd0; dec_log2 = 3'd0; adc_data = 8'h80; enable = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      wait_strobe(n);
      if (i < 8) exp_q.push_back(8'(8'h80 + i));
      adc_data = 8'(8'h81 + i);
    end
    tick();
    clear_overflow = 1'b1;
    wait_strobe(n);
    clear_overflow = 1'b0;
    check_val("set_wins_strobe", n, 32'd1);
    check_val("set_wins_ovf", overflow, 32'd1);
    reset = 1'b1;
    tick();
    exp_q.delete();
    check_val("mid_rst_adc_clock", adc_clock, 32'd0);
    check_val("mid_rst_valid", out_valid, 32'd0);
    check_val("mid_rst_data", out_data, 32'd0);
    check_val("mid_rst_count", fifo_count, 32'd0);
    check_val("mid_rst_ovf", overflow, 32'd0);
    reset = 1'b0;
    enable = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
